result_bcd_converter: RTL and testbench

//  Sequential two's-complement to sign/magnitude/BCD converter for arithmetic results.

---
 rtl/result_bcd_pkg.sv | 15 +
 rtl/result_bcd_converter_if.sv | 39 +++
 rtl/bcd_add3_digit.sv | 11 +
 rtl/result_bcd_converter.sv | 129 ++++++++++++
 tb/tb_result_bcd_converter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/result_bcd_pkg.sv
// Shared types and constants for the result-to-BCD converter.
// Contains the FSM state encoding and the shift-and-add-3 digit constants.
package result_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/result_bcd_converter_if.sv
// Request/result bundle between the result register, the converter and the display stage.
// Optional feature macro: RESULT_BCD_BLANK_EN adds the leading-zero blank_mask signal.
interface result_bcd_converter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
);

  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  done;
  logic                  sign_value;
  logic [31:0]           magnitude;
  logic [4*DIGITS-1:0]   bcd_digits;
`ifdef RESULT_BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start, data_in,
    input  ready, done, sign_value, magnitude, bcd_digits, blank_mask
  );

  modport slave (
    input  start, data_in,
    output ready, done, sign_value, magnitude, bcd_digits, blank_mask
  );
`else
  modport master (
    output start, data_in,
    input  ready, done, sign_value, magnitude, bcd_digits
  );

  modport slave (
    input  start, data_in,
    output ready, done, sign_value, magnitude, bcd_digits
  );
`endif

endinterface

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: digits of 5 or more get +3 before the shift.
module bcd_add3_digit
  import result_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESHOLD) ? (i_digit + ADD3_VALUE) : i_digit;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential two's-complement to sign/magnitude/BCD converter, one double-dabble bit per clock.
// Optional feature macro: RESULT_BCD_BLANK_EN registers a leading-zero blank_mask with the digits.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  result_bcd_converter_if.slave   conv
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  conv_state_t           r_state;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_abs;
  logic                  r_sign;
  logic [BCD_W-1:0]      r_bcd;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_sign_value;
  logic [31:0]           r_magnitude;
  logic [BCD_W-1:0]      r_bcd_digits;

  logic [DATA_WIDTH-1:0] w_abs;
  logic                  w_neg;
  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W-1:0]      w_bcd_next;

  // Operand magnitude is unsigned, so the most-negative input needs no overflow handling
  always_comb begin
    w_abs      = conv.data_in[DATA_WIDTH-1] ? (~conv.data_in + DATA_WIDTH'(1)) : conv.data_in;
    w_neg      = conv.data_in[DATA_WIDTH-1] & (|conv.data_in);
    w_bcd_next = (w_adj << 1) | BCD_W'(r_shift[DATA_WIDTH-1]);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef RESULT_BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank_mask;

  function automatic logic [DIGITS-1:0] f_blank(input logic [BCD_W-1:0] bcd);
    logic all_zero;
    f_blank  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero & (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      f_blank[i] = all_zero;
    end
  endfunction

  assign conv.blank_mask = r_blank_mask;
`endif

  // Conversion FSM; the final shift also loads the output registers so done and data align
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_shift      <= '0;
      r_abs        <= '0;
      r_sign       <= 1'b0;
      r_bcd        <= '0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_sign_value <= 1'b0;
      r_magnitude  <= 32'd0;
      r_bcd_digits <= '0;
`ifdef RESULT_BCD_BLANK_EN
      r_blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (conv.start) begin
            r_sign  <= w_neg;
            r_abs   <= w_abs;
            r_shift <= w_abs;
            r_bcd   <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= r_shift << 1;
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(DATA_WIDTH - 1)) begin
            r_state      <= DONE;
            r_done       <= 1'b1;
            r_sign_value <= r_sign;
            r_magnitude  <= 32'(r_abs);
            r_bcd_digits <= w_bcd_next;
`ifdef RESULT_BCD_BLANK_EN
            r_blank_mask <= f_blank(w_bcd_next);
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign conv.ready      = r_ready;
  assign conv.done       = r_done;
  assign conv.sign_value = r_sign_value;
  assign conv.magnitude  = r_magnitude;
  assign conv.bcd_digits = r_bcd_digits;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: stimulus pushes expected results, a monitor checks each done.
module tb_result_bcd_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic        sign;
    logic [31:0] mag;
    logic [19:0] bcd;
    logic [4:0]  blank;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  result_bcd_converter_if #(.DATA_WIDTH(16), .DIGITS(5)) bus ();

  result_bcd_converter #(.DATA_WIDTH(16), .DIGITS(5)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .conv    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", cyc, mon_e.due);
        check("sign_value", {31'd0, bus.sign_value}, {31'd0, mon_e.sign});
        check("magnitude", bus.magnitude, mon_e.mag);
        check("bcd_digits", {12'd0, bus.bcd_digits}, {12'd0, mon_e.bcd});
`ifdef RESULT_BCD_BLANK_EN
        check("blank_mask", {27'd0, bus.blank_mask}, {27'd0, mon_e.blank});
`endif
      end
    end
  end

  task automatic issue(input logic [15:0] d, input logic sgn, input logic [31:0] mag,
                       input logic [19:0] bcd, input logic [4:0] blank);
    exp_t e;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = d;
    e = '{sign: sgn, mag: mag, bcd: bcd, blank: blank, due: cyc + 17};
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.data_in = 16'hA5A5;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 80) begin
      @(posedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    exp_t e;
    bus.start   = 1'b0;
    bus.data_in = 16'd0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sign", {31'd0, bus.sign_value}, 32'd0);
    check("rst_mag", bus.magnitude, 32'd0);
    check("rst_bcd", {12'd0, bus.bcd_digits}, 32'd0);
`ifdef RESULT_BCD_BLANK_EN
    check("rst_blank", {27'd0, bus.blank_mask}, 32'b11110);
`endif
    rst_n = 1'b1;

    // Directed vectors: data, sign, magnitude, bcd, blank
    issue(16'd0,     1'b0, 32'd0,     20'h00000, 5'b11110); drain();
    issue(16'd12345, 1'b0, 32'd12345, 20'h12345, 5'b00000); drain();
    issue(16'hFFFF,  1'b1, 32'd1,     20'h00001, 5'b11110); drain();
    issue(16'h8000,  1'b1, 32'd32768, 20'h32768, 5'b00000); drain();
    issue(16'd42,    1'b0, 32'd42,    20'h00042, 5'b11100); drain();
    issue(16'hFC19,  1'b1, 32'd999,   20'h00999, 5'b11000); drain();
    issue(16'd32767, 1'b0, 32'd32767, 20'h32767, 5'b00000); drain();

    // Start while busy is ignored
    issue(16'd999, 1'b0, 32'd999, 20'h00999, 5'b11000);
    repeat (4) @(posedge clk);
    #1;
    check("busy_ready", {31'd0, bus.ready}, 32'd0);
    bus.start   = 1'b1;
    bus.data_in = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    repeat (25) @(posedge clk);

    // Reset mid-conversion: no done, reset values restored
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = 16'd12345;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_sign", {31'd0, bus.sign_value}, 32'd0);
    check("abort_mag", bus.magnitude, 32'd0);
    check("abort_bcd", {12'd0, bus.bcd_digits}, 32'd0);
`ifdef RESULT_BCD_BLANK_EN
    check("abort_blank", {27'd0, bus.blank_mask}, 32'b11110);
`endif
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_idle_ready", {31'd0, bus.ready}, 32'd1);

    // Back-to-back with start held high; data_in change lands on the second capture only
    @(posedge clk); #1;
    n = cyc;
    bus.start   = 1'b1;
    bus.data_in = 16'd7;
    e = '{sign: 1'b0, mag: 32'd7, bcd: 20'h00007, blank: 5'b11110, due: n + 17};
    sb_q.push_back(e);
    e = '{sign: 1'b0, mag: 32'd300, bcd: 20'h00300, blank: 5'b11000, due: n + 35};
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.data_in = 16'd300;
    repeat (18) @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
